counter_ngay_thang: RTL and testbench



---
 rtl/counter_ngay_thang.sv | 84 ++++++++
 tb/tb_counter_ngay_thang.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/counter_ngay_thang.sv
// Day-of-month / month counter for the calendar chain. Sizes February from the
// year counter's leap flag and emits the Dec 31 -> Jan 1 carry as year_inc.
module counter_ngay_thang #(
  parameter int unsigned RESET_DAY   = 1,
  parameter int unsigned RESET_MONTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_auto,
  input  logic       inc_day_manual,
  input  logic       dec_day_manual,
  input  logic       inc_month_manual,
  input  logic       dec_month_manual,
  input  logic       leap,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [4:0] max_day,
  output logic       year_inc
);

  localparam logic [4:0] RST_DAY   = 5'(RESET_DAY);
  localparam logic [3:0] RST_MONTH = 4'(RESET_MONTH);

  logic [4:0] day_q, day_d;
  logic [3:0] month_q, month_d;
  logic [3:0] month_up, month_dn;
  logic [4:0] max_up, max_dn;

  function automatic logic [4:0] days_in(input logic [3:0] m, input logic lp);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: days_in = 5'd30;
      4'd2:                    days_in = lp ? 5'd29 : 5'd28;
      default:                 days_in = 5'd31;
    endcase
  endfunction

  // Range compares (>=, <=) let an out-of-range month wrap back into 1..12.
  assign month_up = (month_q >= 4'd12) ? 4'd1  : month_q + 4'd1;
  assign month_dn = (month_q <= 4'd1)  ? 4'd12 : month_q - 4'd1;
  assign max_day  = days_in(month_q, leap);
  assign max_up   = days_in(month_up, leap);
  assign max_dn   = days_in(month_dn, leap);

  always_comb begin
    day_d   = day_q;
    month_d = month_q;
    if (inc_auto) begin
      if (day_q >= max_day) begin
        day_d   = 5'd1;
        month_d = month_up;
      end else begin
        day_d = day_q + 5'd1;
      end
    end else if (inc_day_manual) begin
      day_d = (day_q >= max_day) ? 5'd1 : day_q + 5'd1;
    end else if (dec_day_manual) begin
      day_d = (day_q <= 5'd1) ? max_day : day_q - 5'd1;
    end else if (inc_month_manual) begin
      month_d = month_up;
      day_d   = (day_q > max_up) ? max_up : day_q;
    end else if (dec_month_manual) begin
      month_d = month_dn;
      day_d   = (day_q > max_dn) ? max_dn : day_q;
    end else if (day_q > max_day) begin
      // Idle-cycle clamp, e.g. 29 Feb after leap drops.
      day_d = max_day;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      day_q   <= RST_DAY;
      month_q <= RST_MONTH;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
    end
  end

  assign day      = day_q;
  assign month    = month_q;
  assign year_inc = inc_auto & ~rst & (month_q == 4'd12) & (day_q >= max_day);

endmodule

// File: tb/tb_counter_ngay_thang.sv
// Scoreboard bench: stimulus pushes per-cycle expectations from a calendar
// model; a negedge monitor pops and compares against the DUT outputs.
module tb_counter_ngay_thang;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inc_auto = 1'b0, inc_day_manual = 1'b0, dec_day_manual = 1'b0;
  logic       inc_month_manual = 1'b0, dec_month_manual = 1'b0, leap = 1'b0;
  logic [4:0] day, max_day;
  logic [3:0] month;
  logic       year_inc;

  counter_ngay_thang #(.RESET_DAY(1), .RESET_MONTH(1)) dut (
    .clk(clk), .rst(rst), .inc_auto(inc_auto),
    .inc_day_manual(inc_day_manual), .dec_day_manual(dec_day_manual),
    .inc_month_manual(inc_month_manual), .dec_month_manual(dec_month_manual),
    .leap(leap), .day(day), .month(month), .max_day(max_day), .year_inc(year_inc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit chk;
    int cyc;
    int d, m, mx, yi;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  int   md = 0, mm = 0;
  bit   known = 0;

  function automatic int mdays(int m, bit lp);
    int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && lp) return 29;
    return tbl[m-1];
  endfunction

  // One cycle: drive inputs, record what the DUT must show this cycle, then
  // advance the calendar model to the state after the next edge.
  task automatic step(bit r, bit ai, bit id, bit dd, bit im, bit dm, bit lp);
    exp_t e;
    int   mx, nm;
    @(posedge clk); #1;
    rst = r; inc_auto = ai; inc_day_manual = id; dec_day_manual = dd;
    inc_month_manual = im; dec_month_manual = dm; leap = lp;
    cyc++;
    e.chk = known; e.cyc = cyc; e.d = md; e.m = mm;
    mx = known ? mdays(mm, lp) : 0;
    e.mx = mx;
    e.yi = (!r && ai && mm == 12 && md >= mx) ? 1 : 0;
    q.push_back(e);
    if (r) begin
      md = 1; mm = 1; known = 1;
    end else if (ai) begin
      if (md >= mx) begin md = 1; mm = (mm % 12) + 1; end
      else md = md + 1;
    end else if (id) begin
      md = (md >= mx) ? 1 : md + 1;
    end else if (dd) begin
      md = (md <= 1) ? mx : md - 1;
    end else if (im || dm) begin
      nm = im ? (mm % 12) + 1 : ((mm + 10) % 12) + 1;
      mm = nm;
      if (md > mdays(nm, lp)) md = mdays(nm, lp);
    end else if (md > mx) begin
      md = mx;
    end
  endtask

  task automatic idle(bit lp);
    step(0, 0, 0, 0, 0, 0, lp);
  endtask

  // Reset to 1 Jan, then walk to (m, d) with manual pulses.
  task automatic goto_date(int m, int d, bit lp);
    step(1, 0, 0, 0, 0, 0, lp);
    for (int i = 1; i < m; i++) step(0, 0, 0, 0, 1, 0, lp);
    for (int i = 1; i < d; i++) step(0, 0, 1, 0, 0, 0, lp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        n_cmp++;
        if (day !== 5'(e.d) || month !== 4'(e.m) ||
            max_day !== 5'(e.mx) || year_inc !== 1'(e.yi)) begin
          n_bad++;
          $display("FAIL cycle%0d: got day=%0d month=%0d max_day=%0d year_inc=%0d, want day=%0d month=%0d max_day=%0d year_inc=%0d",
                   e.cyc, day, month, max_day, year_inc, e.d, e.m, e.mx, e.yi);
        end
      end
    end
  end

  initial begin
    // Reset held two cycles with every pulse active.
    step(1, 1, 1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1, 1, 1);
    idle(0); idle(0);

    // February length.
    goto_date(2, 28, 1);
    step(0, 1, 0, 0, 0, 0, 1); step(0, 1, 0, 0, 0, 0, 1); idle(1);
    goto_date(2, 28, 0);
    step(0, 1, 0, 0, 0, 0, 0); idle(0);

    // Year carry and the non-carrying November wrap.
    goto_date(12, 31, 0);
    step(0, 1, 0, 0, 0, 0, 0); idle(0);
    goto_date(11, 30, 0);
    step(0, 1, 0, 0, 0, 0, 0); idle(0);

    // Manual wraps and clamps.
    goto_date(3, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0); idle(0);
    step(0, 0, 0, 0, 0, 1, 1); idle(1);
    goto_date(1, 31, 0);
    step(0, 0, 0, 0, 1, 0, 0); idle(0);
    goto_date(12, 5, 0);
    step(0, 0, 0, 0, 1, 0, 0); step(0, 0, 0, 0, 0, 1, 0); idle(0);

    // Leap drop at 29 Feb clamps on the next idle edge.
    goto_date(2, 29, 1);
    idle(1); idle(0); idle(0);

    // Simultaneous pulses, and reset racing a year carry.
    goto_date(6, 10, 0);
    step(0, 1, 0, 1, 1, 0, 0); idle(0);
    goto_date(12, 31, 0);
    step(1, 1, 0, 0, 0, 0, 0); idle(0);

    // Randomized traffic.
    begin
      bit lp = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 19) == 0) lp = ~lp;
        step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, lp);
      end
    end

    @(posedge clk); #1;
    rst = 0; inc_auto = 0; inc_day_manual = 0; dec_day_manual = 0;
    inc_month_manual = 0; dec_month_manual = 0;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
